// File: rtl/sampler_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered 1-bit sampler among NUM_REQ requesters.
// Optional per-requester grant counters are enabled with SAMPLER_RR_ARBITER_GNT_CNT_EN.
module sampler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0] gnt,
    output logic               res_en,
    output logic               res_in,
    input  logic               res_out,
    output logic               resp_valid,
    output logic [ID_W-1:0]    resp_id,
    output logic               resp_data
`ifdef SAMPLER_RR_ARBITER_GNT_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic [ID_W-1:0]    id, id_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic               res_en_n, res_in_n;
    logic               resp_valid_n, resp_data_n;
    logic [ID_W-1:0]    resp_id_n;
    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;

    // First requester after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        id_n         = id;
        cnt_n        = cnt;
        gnt_n        = '0;
        res_en_n     = 1'b0;
        res_in_n     = 1'b0;
        resp_valid_n = 1'b0;
        resp_id_n    = resp_id;
        resp_data_n  = resp_data;
        case (state)
            IDLE: begin
                // Outputs are registered, so ISSUE-cycle values are prepared here.
                if (found) begin
                    id_n     = winner;
                    gnt_n    = NUM_REQ'(1) << winner;
                    res_en_n = 1'b1;
                    res_in_n = req_data[winner];
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = CNT_W'(LATENCY);
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    resp_data_n  = res_out;
                    resp_id_n    = id;
                    resp_valid_n = 1'b1;
                    state_n      = DONE;
                end
            end
            DONE: begin
                ptr_n   = id;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= ID_W'(NUM_REQ - 1);
            id         <= '0;
            cnt        <= '0;
            gnt        <= '0;
            res_en     <= 1'b0;
            res_in     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            id         <= id_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            res_en     <= res_en_n;
            res_in     <= res_in_n;
            resp_valid <= resp_valid_n;
            resp_id    <= resp_id_n;
            resp_data  <= resp_data_n;
        end
    end

`ifdef SAMPLER_RR_ARBITER_GNT_CNT_EN
    logic [NUM_REQ-1:0][15:0] gcnt;

    // Saturating count of ISSUE cycles per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && gcnt[i] != 16'hFFFF)
                    gcnt[i] <= gcnt[i] + 16'd1;
            end
        end
    end

    assign grant_cnt = gcnt;
`endif

endmodule
